// File: rtl/concat_pack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : concat_pack_pkg
//  Description : Shared state encodings, width helper and lane mapping for the
//                concat_pack serial-to-parallel packer.
//  Revision    : 1.0 - initial release
// ============================================================================
package concat_pack_pkg;

  // Packer state: collecting beats, or presenting a finished word
  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Ceiling log2, used for the fill counter width (value >= 2 in practice)
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Map a beat's position within the word to its physical lane
  function automatic int lane_index(input int cnt, input logic order, input int lanes);
    return order ? (lanes - 1 - cnt) : cnt;
  endfunction

endpackage : concat_pack_pkg
`default_nettype wire

// File: rtl/concat_pack.sv
`default_nettype none
// ============================================================================
//  Module      : concat_pack
//  Description : Packs NUM_LANES beats of LANE_W bits into one word, with
//                run-time lane ordering and zero-padded partial flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module concat_pack
  import concat_pack_pkg::*;
#(
  parameter int LANE_W    = 1,
  parameter int NUM_LANES = 2,
  localparam int OUT_W    = LANE_W * NUM_LANES,
  localparam int CNT_W    = clog2(NUM_LANES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LANE_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             msb_first,
  input  logic             flush,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_LANES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_LANES);

  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic [OUT_W-1:0] data_r, data_n;
  logic [CNT_W-1:0] ocount_r, ocount_n;
  logic             order_r, order_n;

  logic             accept;
  logic             take_beat;
  logic             beat_order;
  logic [OUT_W-1:0] packed_word;
  int               lane_sel;

  assign in_ready  = !rst && (state == ST_FILL || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_HOLD);
  assign out_data  = data_r;
  assign out_count = ocount_r;

  // Next-state logic: lane placement, completion, flush and hand-off
  always_comb begin
    state_n     = state;
    count_n     = count;
    data_n      = data_r;
    ocount_n    = ocount_r;
    order_n     = order_r;
    take_beat   = 1'b0;

    // First beat of a word latches the order and starts from a clean word;
    // in HOLD the counter is already zero so this also covers hand-off beats.
    beat_order  = (count == '0) ? msb_first : order_r;
    packed_word = (count == '0) ? '0 : data_r;
    lane_sel    = lane_index(int'(count), beat_order, NUM_LANES);
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_sel == i) begin
        packed_word[i*LANE_W +: LANE_W] = in_data;
      end
    end

    unique case (state)
      ST_FILL: begin
        if (accept) begin
          take_beat = 1'b1;
        end else if (flush && count != '0) begin
          state_n  = ST_HOLD;
          ocount_n = count;
          count_n  = '0;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_n = ST_FILL;
          if (accept) begin
            take_beat = 1'b1;
          end
        end
      end
      default: state_n = ST_FILL;
    endcase

    if (take_beat) begin
      data_n  = packed_word;
      order_n = beat_order;
      if (count == LAST_CNT) begin
        state_n  = ST_HOLD;
        ocount_n = FULL_CNT;
        count_n  = '0;
      end else if (flush && state == ST_FILL) begin
        state_n  = ST_HOLD;
        ocount_n = count + CNT_W'(1);
        count_n  = '0;
      end else begin
        count_n  = count + CNT_W'(1);
      end
    end
  end

  // State register with synchronous reset discarding any partial/held word
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FILL;
      count    <= '0;
      data_r   <= '0;
      ocount_r <= '0;
      order_r  <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      data_r   <= data_n;
      ocount_r <= ocount_n;
      order_r  <= order_n;
    end
  end

endmodule : concat_pack
`default_nettype wire
